// File: rtl/if_demod_pkg.sv
// Shared widths, output saturation bounds and window limits for the IF demodulator.
package if_demod_pkg;
  localparam int DW        = 16;
  localparam int LW        = 18;
  localparam int AW        = 42;
  localparam int OUT_SHIFT = 17;
  localparam int RW        = 18;

  localparam logic signed [RW-1:0] SAT_MAX = 18'sh1FFFF;
  localparam logic signed [RW-1:0] SAT_MIN = 18'sh20000;

  localparam logic [7:0] MIN_PERIOD = 8'd4;
endpackage

// File: rtl/iq_mac.sv
// One mixer arm: registered product, window accumulator and dump-hold register.
module iq_mac
  import if_demod_pkg::*;
#(
  parameter int dw = DW,
  parameter int lw = LW,
  parameter int aw = AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [dw-1:0] adc_p0,
  input  logic signed [lw-1:0] lo_p0,
  input  logic                 start_p1,
  input  logic                 last_p1,
  output logic signed [aw-1:0] hold
);
  localparam int pw = dw + lw;

  logic signed [pw-1:0] prod_p1_d, prod_p1_q;
  logic signed [aw-1:0] acc_p2_d, acc_p2_q;
  logic signed [aw-1:0] hold_p2_d, hold_p2_q;
  logic signed [aw-1:0] prod_ext, sum;

  always_comb begin
    prod_p1_d = pw'(adc_p0) * pw'(lo_p0);
    prod_ext  = aw'(prod_p1_q);
    sum       = acc_p2_q + prod_ext;
    hold_p2_d = hold_p2_q;
    acc_p2_d  = sum;
    // A window start (possibly forced by sync) drops whatever partial sum was pending.
    if (last_p1) begin
      hold_p2_d = sum;
      acc_p2_d  = '0;
    end else if (start_p1) begin
      acc_p2_d  = prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_p1_q <= '0;
      acc_p2_q  <= '0;
      hold_p2_q <= '0;
    end else begin
      // stage 1: multiply
      prod_p1_q <= prod_p1_d;
      // stage 2: accumulate / dump
      acc_p2_q  <= acc_p2_d;
      hold_p2_q <= hold_p2_d;
    end
  end

  assign hold = hold_p2_q;
endmodule

// File: rtl/if_demod.sv
// IF demodulator: mixes one ADC stream with an LO pair, integrates per window, emits an I/Q burst.
module if_demod
  import if_demod_pkg::*;
#(
  parameter int dw        = DW,
  parameter int lw        = LW,
  parameter int aw        = AW,
  parameter int out_shift = OUT_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [dw-1:0] adc,
  input  logic signed [lw-1:0] lo_cos,
  input  logic signed [lw-1:0] lo_sin,
  input  logic                 sync,
  input  logic [7:0]           period,
  output logic signed [RW-1:0] result,
  output logic                 result_iq,
  output logic                 result_valid
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_I    = 2'd1;
  localparam logic [1:0] S_Q    = 2'd2;

  logic signed [dw-1:0] adc_p0_q;
  logic signed [lw-1:0] cos_p0_q, sin_p0_q;
  logic                 start_p0_d, start_p0_q, last_p0_d, last_p0_q;
  logic                 start_p1_q, last_p1_q, dump_p2_q;
  logic [7:0]           cnt_d, cnt_q, win_d, win_q, cur;
  logic [1:0]           state_d, state_q;
  logic signed [RW-1:0] result_d, result_q;
  logic signed [aw-1:0] hold_i, hold_q;

  function automatic logic signed [RW-1:0] sat_out(input logic signed [aw-1:0] h);
    logic signed [aw-1:0] y;
    y = h >>> out_shift;
    if (y > aw'(SAT_MAX))      return SAT_MAX;
    else if (y < aw'(SAT_MIN)) return SAT_MIN;
    else                       return y[RW-1:0];
  endfunction

  // Window framing is decided as each sample arrives and then travels with it.
  always_comb begin
    start_p0_d = (cnt_q == 8'd0) || sync;
    win_d      = win_q;
    cur        = cnt_q;
    if (start_p0_d) begin
      win_d = (period < MIN_PERIOD) ? MIN_PERIOD : period;
      cur   = 8'd0;
    end
    last_p0_d = (cur == win_d - 8'd1);
    cnt_d     = last_p0_d ? 8'd0 : cur + 8'd1;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (dump_p2_q) begin
        state_d  = S_I;
        result_d = sat_out(hold_i);
      end
      S_I: begin
        state_d  = S_Q;
        result_d = sat_out(hold_q);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adc_p0_q   <= '0;
      cos_p0_q   <= '0;
      sin_p0_q   <= '0;
      start_p0_q <= 1'b0;
      last_p0_q  <= 1'b0;
      start_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
      dump_p2_q  <= 1'b0;
      cnt_q      <= '0;
      win_q      <= MIN_PERIOD;
      state_q    <= S_IDLE;
      result_q   <= '0;
    end else begin
      // stage 0: input register
      adc_p0_q   <= adc;
      cos_p0_q   <= lo_cos;
      sin_p0_q   <= lo_sin;
      start_p0_q <= start_p0_d;
      last_p0_q  <= last_p0_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      // stage 1: framing flags follow the products
      start_p1_q <= start_p0_q;
      last_p1_q  <= last_p0_q;
      // stage 2: dump strobe aligned with hold registers
      dump_p2_q  <= last_p1_q;
      // output burst
      state_q    <= state_d;
      result_q   <= result_d;
    end
  end

  iq_mac #(.dw(dw), .lw(lw), .aw(aw)) u_mac_i (
    .clk(clk), .rst_n(rst_n), .adc_p0(adc_p0_q), .lo_p0(cos_p0_q),
    .start_p1(start_p1_q), .last_p1(last_p1_q), .hold(hold_i)
  );

  iq_mac #(.dw(dw), .lw(lw), .aw(aw)) u_mac_q (
    .clk(clk), .rst_n(rst_n), .adc_p0(adc_p0_q), .lo_p0(sin_p0_q),
    .start_p1(start_p1_q), .last_p1(last_p1_q), .hold(hold_q)
  );

  assign result       = result_q;
  assign result_iq    = (state_q == S_I);
  assign result_valid = (state_q == S_I) || (state_q == S_Q);
endmodule
